// File: rtl/dff.sv
// Loadable WIDTH-bit register with synchronous reset, change-detect pulse and gated output.
// Define DFF_TRISTATE_EN to float o_Q (all Z) when i_enable=0; otherwise o_Q drives zeros.
module dff #(
    parameter int              WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_D,
    output logic [WIDTH-1:0] o_Q,
    output logic [WIDTH-1:0] o_state,
    output logic             o_changed
);

    logic [WIDTH-1:0] stored;
    logic             changed;

    // Reset has priority over load; changed only fires when a load alters the value.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stored  <= RESET_VALUE;
            changed <= 1'b0;
        end else if (i_load) begin
            stored  <= i_D;
            changed <= (i_D != stored);
        end else begin
            changed <= 1'b0;
        end
    end

    assign o_state   = stored;
    assign o_changed = changed;

`ifdef DFF_TRISTATE_EN
    assign o_Q = i_enable ? stored : {WIDTH{1'bz}};
`else
    assign o_Q = i_enable ? stored : {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_dff.sv
// Directed self-checking bench for dff: a 1-bit instance (reset 0) and an 8-bit instance (reset 0x3C).
module tb_dff;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic       rst_a, load_a, en_a, changed_a;
    logic [0:0] d_a, q_a, state_a;
    logic       rst_b, load_b, en_b, changed_b;
    logic [7:0] d_b, q_b, state_b;

    logic [7:0] exp_q[$];
    logic       exp_chg_q[$];

    dff #(.WIDTH(1), .RESET_VALUE(1'b0)) dut_a (
        .i_clk(clk), .i_rst(rst_a), .i_load(load_a), .i_enable(en_a),
        .i_D(d_a), .o_Q(q_a), .o_state(state_a), .o_changed(changed_a)
    );

    dff #(.WIDTH(8), .RESET_VALUE(8'h3C)) dut_b (
        .i_clk(clk), .i_rst(rst_b), .i_load(load_b), .i_enable(en_b),
        .i_D(d_b), .o_Q(q_b), .o_state(state_b), .o_changed(changed_b)
    );

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; load_a = 1'b0; en_a = 1'b1; d_a = 1'b1;
        rst_b = 1'b1; load_b = 1'b0; en_b = 1'b1; d_b = 8'hFF;
        step();
        vectors++; if (state_a !== 1'b0) begin miscompares++; $display("FAIL reset_state_a got=%b exp=0", state_a); end
        vectors++; if (changed_a !== 1'b0) begin miscompares++; $display("FAIL reset_changed_a got=%b exp=0", changed_a); end
        vectors++; if (q_a !== 1'b0) begin miscompares++; $display("FAIL reset_q_a got=%b exp=0", q_a); end
        vectors++; if (state_b !== 8'h3C) begin miscompares++; $display("FAIL reset_state_b got=%h exp=3c", state_b); end
        vectors++; if (changed_b !== 1'b0) begin miscompares++; $display("FAIL reset_changed_b got=%b exp=0", changed_b); end
        vectors++; if (q_b !== 8'h3C) begin miscompares++; $display("FAIL reset_q_b got=%h exp=3c", q_b); end
        rst_a = 1'b0;
        rst_b = 1'b0;
    endtask

    task automatic test_no_edge();
        load_a = 1'b1; en_a = 1'b1; d_a = 1'b0;
        #1 d_a = 1'b1;
        #1;
        vectors++; if (q_a !== 1'b0) begin miscompares++; $display("FAIL no_edge_q_hi got=%b exp=0", q_a); end
        vectors++; if (state_a !== 1'b0) begin miscompares++; $display("FAIL no_edge_state got=%b exp=0", state_a); end
        d_a = 1'b0;
        #1;
        vectors++; if (q_a !== 1'b0) begin miscompares++; $display("FAIL no_edge_q_lo got=%b exp=0", q_a); end
        step();
        vectors++; if (changed_a !== 1'b0) begin miscompares++; $display("FAIL no_edge_same_load_changed got=%b exp=0", changed_a); end
    endtask

    task automatic test_load();
        d_a = 1'b1; load_a = 1'b1;
        step();
        load_a = 1'b0;
        vectors++; if (q_a !== 1'b1) begin miscompares++; $display("FAIL load_q got=%b exp=1", q_a); end
        vectors++; if (state_a !== 1'b1) begin miscompares++; $display("FAIL load_state got=%b exp=1", state_a); end
        vectors++; if (changed_a !== 1'b1) begin miscompares++; $display("FAIL load_changed got=%b exp=1", changed_a); end
        step();
        vectors++; if (changed_a !== 1'b0) begin miscompares++; $display("FAIL load_changed_drop got=%b exp=0", changed_a); end
        vectors++; if (state_a !== 1'b1) begin miscompares++; $display("FAIL load_hold got=%b exp=1", state_a); end
    endtask

    task automatic test_reset_no_edge();
        rst_a = 1'b1;
        #2;
        vectors++; if (q_a !== 1'b1) begin miscompares++; $display("FAIL rst_no_edge_q got=%b exp=1", q_a); end
        step();
        vectors++; if (q_a !== 1'b0) begin miscompares++; $display("FAIL rst_edge_q got=%b exp=0", q_a); end
        rst_a = 1'b0;
    endtask

    task automatic test_reset_load();
        d_b = 8'h11; load_b = 1'b1;
        step();
        vectors++; if (changed_b !== 1'b1) begin miscompares++; $display("FAIL pre_rst_changed_b got=%b exp=1", changed_b); end
        rst_b = 1'b1; d_b = 8'hA5;
        rst_a = 1'b1; load_a = 1'b1; d_a = 1'b1;
        step();
        vectors++; if (state_b !== 8'h3C) begin miscompares++; $display("FAIL rst_load_state_b got=%h exp=3c", state_b); end
        vectors++; if (changed_b !== 1'b0) begin miscompares++; $display("FAIL rst_load_changed_b got=%b exp=0", changed_b); end
        vectors++; if (state_a !== 1'b0) begin miscompares++; $display("FAIL rst_load_state_a got=%b exp=0", state_a); end
        rst_a = 1'b0; load_a = 1'b0;
        rst_b = 1'b0;
        step();
        vectors++; if (state_b !== 8'hA5) begin miscompares++; $display("FAIL post_rst_load got=%h exp=a5", state_b); end
        vectors++; if (changed_b !== 1'b1) begin miscompares++; $display("FAIL post_rst_changed got=%b exp=1", changed_b); end
    endtask

    task automatic test_same_value();
        d_b = 8'h5A; load_b = 1'b1;
        step();
        vectors++; if (changed_b !== 1'b1) begin miscompares++; $display("FAIL same_first_changed got=%b exp=1", changed_b); end
        step();
        vectors++; if (state_b !== 8'h5A) begin miscompares++; $display("FAIL same_state got=%h exp=5a", state_b); end
        vectors++; if (changed_b !== 1'b0) begin miscompares++; $display("FAIL same_changed got=%b exp=0", changed_b); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [4] = '{8'h01, 8'h02, 8'h02, 8'hFE};
        logic [7:0] prev = 8'h5A;
        logic [7:0] exp_v;
        logic       exp_c;
        foreach (vals[i]) begin
            exp_q.push_back(vals[i]);
            exp_chg_q.push_back(vals[i] != prev);
            prev = vals[i];
        end
        load_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d_b = vals[i];
            step();
            exp_v = exp_q.pop_front();
            exp_c = exp_chg_q.pop_front();
            vectors++; if (state_b !== exp_v) begin miscompares++; $display("FAIL b2b_state[%0d] got=%h exp=%h", i, state_b, exp_v); end
            vectors++; if (changed_b !== exp_c) begin miscompares++; $display("FAIL b2b_changed[%0d] got=%b exp=%b", i, changed_b, exp_c); end
        end
        load_b = 1'b0; d_b = 8'h77;
        step();
        vectors++; if (state_b !== 8'hFE) begin miscompares++; $display("FAIL hold_state got=%h exp=fe", state_b); end
        vectors++; if (changed_b !== 1'b0) begin miscompares++; $display("FAIL hold_changed got=%b exp=0", changed_b); end
    endtask

    task automatic test_enable();
        logic [7:0] exp_off;
`ifdef DFF_TRISTATE_EN
        exp_off = 8'hzz;
`else
        exp_off = 8'h00;
`endif
        d_b = 8'hFF; load_b = 1'b1;
        step();
        load_b = 1'b0; en_b = 1'b0;
        #1;
        vectors++; if (q_b !== exp_off) begin miscompares++; $display("FAIL disabled_q got=%h exp=%h", q_b, exp_off); end
        vectors++; if (state_b !== 8'hFF) begin miscompares++; $display("FAIL disabled_state got=%h exp=ff", state_b); end
        en_b = 1'b1;
        #1;
        vectors++; if (q_b !== 8'hFF) begin miscompares++; $display("FAIL enabled_q got=%h exp=ff", q_b); end
    endtask

    initial begin
        test_reset();
        test_no_edge();
        test_load();
        test_reset_no_edge();
        test_reset_load();
        test_same_value();
        test_back_to_back();
        test_enable();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dff.md
DFF -- requirements
Module: dff

Interface
REQ-001 Parameter WIDTH, default 1, width of the data path in bits (legal 1..64).
REQ-002 Parameter RESET_VALUE, default 0 (all zeros), value loaded into the storage register on reset.
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  reset; synchronous and active-high.
REQ-005 i_load  input  1  capture enable; when high, i_D is stored at the next rising edge.
REQ-006 i_enable  input  1  output enable for o_Q.
REQ-007 i_D  input  WIDTH  data to be stored.
REQ-008 o_Q  output  WIDTH  gated view of the stored value, per REQ-014.
REQ-009 o_state  output  WIDTH  stored value, always visible and ungated.
REQ-010 o_changed  output  1  one-cycle pulse, high for the cycle after a load that altered the stored value.

Function
REQ-011 Storage register updates only on a rising edge of i_clk.
- Changes on i_D, i_load or i_enable between edges shall not alter the stored value.
REQ-012 At a rising edge with i_rst=0 and i_load=1, the stored value shall become i_D.
- Visible on o_state in the same cycle, with no extra latency.
REQ-013 At a rising edge with i_rst=0 and i_load=0, the stored value shall hold.
REQ-014 o_Q is combinational from the stored value and i_enable.
- i_enable=1: o_Q equals o_state.
- i_enable=0: o_Q per REQ-023.
REQ-015 o_changed is registered.
- High for exactly one cycle after an edge where a load (REQ-012) produced a new value different from the previous one.
- Low otherwise, including when the load wrote an identical value.
REQ-016 Simultaneous i_rst=1 and i_load=1 at an edge: reset shall win; i_D shall be ignored.
REQ-017 Back-to-back loads on consecutive edges shall each be captured; no load shall be dropped.
REQ-018 No internal state beyond the storage register and the o_changed flop.

Reset
REQ-019 At a rising edge with i_rst=1:
- stored value becomes RESET_VALUE;
- o_changed becomes 0.
REQ-020 Reset has no effect without a clock edge; the stored value holds until the next rising edge.
REQ-021 After reset deasserts, the first edge with i_load=1 shall capture normally.

Configuration
REQ-022 Macro DFF_TRISTATE_EN selects the o_Q behaviour when i_enable=0.
REQ-023 With DFF_TRISTATE_EN defined:
- o_Q shall be high-impedance (all bits Z) when i_enable=0, for connection to a shared bus.
REQ-023 (continued) Without DFF_TRISTATE_EN:
- o_Q shall drive all zeros when i_enable=0;
- no Z values shall appear on any port.
REQ-024 o_state and o_changed shall behave identically in both configurations.

Verification
REQ-025 WIDTH=1, i_enable=1, i_load=1, no edge; toggle i_D 0->1->0 -> o_Q stays 0.
REQ-026 i_D=1, i_load=1, one rising edge -> o_Q=1, o_state=1, o_changed=1 for the next cycle, then 0.
REQ-027 Stored value 1; i_rst=1 with no edge -> o_Q stays 1; after the next rising edge -> o_Q=0.
REQ-028 Reset and load in the same cycle:
- stimulus: i_rst=1, i_load=1, i_D=1 (WIDTH=8: i_D=0xA5, RESET_VALUE=0x3C);
- at edge -> o_state=0x3C.
REQ-029 WIDTH=8, stored value 0x5A, i_load=1, i_D=0x5A -> o_state=0x5A, o_changed stays 0.
REQ-030 Stored value 0xFF, i_enable=0:
- with DFF_TRISTATE_EN -> o_Q=ZZ;
- without -> o_Q=0x00;
- o_state=0xFF in both.
